sdram_to_fifo_wr_controller: RTL and testbench
==============================================

// Module: sdram_to_fifo_wr_controller
// PURPOSE
//  Return path of the SDRAM stream test: moves 1 KB bursts (512 x 16-bit words) read back from SDRAM
//  into the output (check) FIFO. Requests a burst only when the FIFO has room for a whole burst,
//  counts words as the SDRAM side presents them, and drives FIFO write strobes/data.
//  Mirror of the FIFO->SDRAM read controller on the write-side path; sits between SDRAM read port and scfifo.
// PARAMETERS
//  BURST_LEN   512   16-bit words per burst (1 KB)
//  FIFO_DEPTH  1024  words in output FIFO; fifo_usedw width = 10 bits
//  DATA_W      16    word width
//  SETTLE_CYC  2     idle cycles after a burst before re-evaluating fifo_usedw (scfifo usedw lag)
// PORTS
//  clk            in   1       system clock, all logic on posedge
//  rst_n          in   1       asynchronous active-low reset
//  fifo_usedw     in   10      output FIFO fill level (words)
//  fifo_full      in   1       output FIFO full flag
//  fifo_rx_rdy    out  1       high: FIFO can take a full burst; SDRAM side may start reading
//  sdram_rd_valid in   1       one word on sdram_rd_data this cycle
//  sdram_rd_data  in   DATA_W  word read from SDRAM
//  fifo_wrreq     out  1       FIFO write strobe
//  fifo_data      out  DATA_W  FIFO write data
//  burst_done     out  1       one-cycle pulse: last word of burst written
//  ovf_err        out  1       sticky: word lost (valid outside burst, or fifo_full on write)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, word count=0, settle count=0; fifo_rx_rdy=0, fifo_wrreq=0,
//   fifo_data=0, burst_done=0, ovf_err=0. All outputs registered.
//  States: IDLE -> REQ -> XFER -> SETTLE -> IDLE.
//  IDLE: if (FIFO_DEPTH - fifo_usedw) >= BURST_LEN and !fifo_full -> REQ. Subtraction 11-bit unsigned.
//  REQ: fifo_rx_rdy=1. First sdram_rd_valid -> XFER (that word counted as word 1).
//  XFER: fifo_rx_rdy stays 1; each sdram_rd_valid increments count. Gaps in valid allowed, no timeout.
//   When word BURST_LEN accepted: fifo_rx_rdy=0 next cycle, count cleared -> SETTLE.
//  SETTLE: SETTLE_CYC cycles, fifo_rx_rdy=0 -> IDLE.
//  Datapath latency: fifo_wrreq/fifo_data = sdram_rd_valid/sdram_rd_data delayed exactly 1 cycle,
//   only for words accepted in REQ/XFER. burst_done asserts with the wrreq of word BURST_LEN.
//  Boundaries:
//   - sdram_rd_valid in IDLE/SETTLE: word dropped, no wrreq, ovf_err set.
//   - fifo_full high in the cycle a wrreq is issued: write still issued, ovf_err set; count advances.
//   - fifo_usedw exactly FIFO_DEPTH-BURST_LEN (512): burst allowed; 513: not allowed.
//   - count never exceeds BURST_LEN; an extra valid in the cycle after the last word is in SETTLE -> error.
//   - rst_n low mid-burst: immediate abort, all state/outputs to reset values, partial burst discarded.
//  ovf_err cleared only by reset.
// STRUCTURE
//  Shared package/header (stream_test_defs): BURST_LEN_1KB=512, FIFO_DEPTH=1024, DATA_W=16,
//   state encodings S_IDLE/S_REQ/S_XFER/S_SETTLE.
//  Single module; no sub-module needed (FSM + counter + 1-stage register).
// TESTING
//  1 Reset with usedw=0 -> all outputs 0; release -> fifo_rx_rdy=1 by 2nd clk after rst_n high.
//  2 usedw=0, 512 back-to-back valids, data=0..511 -> 512 wrreqs, data 0..511 each 1 cycle late,
//    burst_done once with wrreq #512, fifo_rx_rdy low for SETTLE_CYC+1 cycles.
//  3 usedw=513 -> fifo_rx_rdy stays 0; drop to 512 -> fifo_rx_rdy=1 next cycle.
//  4 valid every 3rd cycle for 512 words -> exactly 512 wrreqs, burst_done only after last.
//  5 valid pulse while IDLE, usedw=1000 -> no wrreq, ovf_err=1 and stays 1.
//  6 rst_n low after word 200 -> outputs 0 asynchronously; after release new burst counts from 1.

Source files
------------

// File: rtl/sdram_to_fifo_wr_controller_pkg.sv
// Shared constants, state encoding and helpers for the SDRAM -> output FIFO write controller.
package sdram_to_fifo_wr_controller_pkg;

    localparam int unsigned BURST_LEN_1KB = 512;
    localparam int unsigned FIFO_DEPTH    = 1024;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned SETTLE_CYC    = 2;

    localparam int unsigned USEDW_W  = 10;
    localparam int unsigned FREE_W   = 11;
    localparam int unsigned CNT_W    = $clog2(BURST_LEN_1KB);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_XFER   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    // True when the FIFO has room for a whole burst and is not flagging full.
    function automatic logic burst_fits(input logic [USEDW_W-1:0] usedw, input logic full);
        logic [FREE_W-1:0] free_words;
        free_words = FREE_W'(FIFO_DEPTH) - FREE_W'(usedw);
        return (free_words >= FREE_W'(BURST_LEN_1KB)) && !full;
    endfunction

endpackage

// File: rtl/sdram_to_fifo_wr_controller_if.sv
// SDRAM read port / output FIFO signal bundle seen by the write controller.
interface sdram_to_fifo_wr_controller_if;
    import sdram_to_fifo_wr_controller_pkg::*;

    logic [USEDW_W-1:0] fifo_usedw;
    logic               fifo_full;
    logic               fifo_rx_rdy;
    logic               sdram_rd_valid;
    logic [DATA_W-1:0]  sdram_rd_data;
    logic               fifo_wrreq;
    logic [DATA_W-1:0]  fifo_data;
    logic               burst_done;
    logic               ovf_err;

    // Controller side.
    modport master (
        input  fifo_usedw, fifo_full, sdram_rd_valid, sdram_rd_data,
        output fifo_rx_rdy, fifo_wrreq, fifo_data, burst_done, ovf_err
    );

    // Environment side (SDRAM read port + FIFO).
    modport slave (
        output fifo_usedw, fifo_full, sdram_rd_valid, sdram_rd_data,
        input  fifo_rx_rdy, fifo_wrreq, fifo_data, burst_done, ovf_err
    );

endinterface

// File: rtl/sdram_to_fifo_wr_controller.sv
// Moves 512-word SDRAM read bursts into the output FIFO, one burst at a time,
// only when the FIFO can absorb the whole burst.
module sdram_to_fifo_wr_controller
    import sdram_to_fifo_wr_controller_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    sdram_to_fifo_wr_controller_if.master bus
);

    state_t              state;
    logic [CNT_W-1:0]    word_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                accept_c;
    logic                last_word_c;

    // A word is taken only while a burst window is open.
    assign accept_c    = bus.sdram_rd_valid && ((state == S_REQ) || (state == S_XFER));
    assign last_word_c = accept_c && (word_cnt == CNT_W'(BURST_LEN_1KB - 1));

    // Burst sequencing: wait for room, open window, count words, let usedw settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            word_cnt        <= '0;
            settle_cnt      <= '0;
            bus.fifo_rx_rdy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (burst_fits(bus.fifo_usedw, bus.fifo_full)) begin
                        state           <= S_REQ;
                        bus.fifo_rx_rdy <= 1'b1;
                    end
                end
                S_REQ, S_XFER: begin
                    if (accept_c) begin
                        if (last_word_c) begin
                            state           <= S_SETTLE;
                            word_cnt        <= '0;
                            settle_cnt      <= '0;
                            bus.fifo_rx_rdy <= 1'b0;
                        end else begin
                            state    <= S_XFER;
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
                        state      <= S_IDLE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                default: begin
                    state           <= S_IDLE;
                    bus.fifo_rx_rdy <= 1'b0;
                end
            endcase
        end
    end

    // One-stage write path plus sticky loss detection (dropped word or write into full FIFO).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fifo_wrreq <= 1'b0;
            bus.fifo_data  <= '0;
            bus.burst_done <= 1'b0;
            bus.ovf_err    <= 1'b0;
        end else begin
            bus.fifo_wrreq <= accept_c;
            bus.burst_done <= last_word_c;
            if (accept_c) begin
                bus.fifo_data <= bus.sdram_rd_data;
            end
            bus.ovf_err <= bus.ovf_err
                         | (bus.sdram_rd_valid && !accept_c)
                         | (bus.fifo_wrreq && bus.fifo_full);
        end
    end

endmodule

// File: tb/tb_sdram_to_fifo_wr_controller.sv
// Bench for the SDRAM -> FIFO write controller: vector table, directed burst
// sequences and a randomized run against a behavioural burst-window model.
module tb_sdram_to_fifo_wr_controller;
    import sdram_to_fifo_wr_controller_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sdram_to_fifo_wr_controller_if bus ();

    sdram_to_fifo_wr_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: an open/closed burst window with a word tally and cooldown.
    bit          m_window;
    int          m_got;
    int          m_cool;
    logic        m_wrreq;
    logic [15:0] m_data;
    logic        m_done;
    logic        m_ovf;

    typedef struct {
        logic [9:0]  usedw;
        logic        full;
        logic        valid;
        logic [15:0] data;
        logic        e_rdy;
        logic        e_wrreq;
        logic [15:0] e_data;
        logic        e_done;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_window = 0;
        m_got    = 0;
        m_cool   = 0;
        m_wrreq  = 1'b0;
        m_data   = '0;
        m_done   = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] d, input logic [9:0] u, input logic f);
        logic nwr;
        nwr    = m_window && v;
        m_ovf  = m_ovf | (v && !m_window) | (m_wrreq && f);
        m_done = nwr && (m_got == BURST_LEN_1KB - 1);
        if (nwr) m_data = d;
        m_wrreq = nwr;
        if (m_window) begin
            if (v) begin
                m_got++;
                if (m_got == BURST_LEN_1KB) begin
                    m_window = 0;
                    m_got    = 0;
                    m_cool   = SETTLE_CYC;
                end
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if ((1024 - int'(u)) >= 512 && !f) begin
            m_window = 1;
        end
    endtask

    task automatic compare_model();
        check("model_rdy",   32'(bus.fifo_rx_rdy), 32'(m_window));
        check("model_wrreq", 32'(bus.fifo_wrreq),  32'(m_wrreq));
        check("model_data",  32'(bus.fifo_data),   32'(m_data));
        check("model_done",  32'(bus.burst_done),  32'(m_done));
        check("model_ovf",   32'(bus.ovf_err),     32'(m_ovf));
    endtask

    // Drive one cycle of inputs, clock it, then check against the model.
    task automatic tick(input logic v, input logic [15:0] d, input logic [9:0] u, input logic f);
        bus.sdram_rd_valid = v;
        bus.sdram_rd_data  = d;
        bus.fifo_usedw     = u;
        bus.fifo_full      = f;
        @(posedge clk);
        #1;
        model_step(v, d, u, f);
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},   32'(bus.fifo_rx_rdy), 32'd0);
        check({tag, "_wrreq"}, 32'(bus.fifo_wrreq),  32'd0);
        check({tag, "_data"},  32'(bus.fifo_data),   32'd0);
        check({tag, "_done"},  32'(bus.burst_done),  32'd0);
        check({tag, "_ovf"},   32'(bus.ovf_err),     32'd0);
    endtask

    // Asynchronous reset pulse issued mid-cycle; outputs must clear before any edge.
    task automatic apply_reset();
        bus.sdram_rd_valid = 1'b0;
        bus.sdram_rd_data  = '0;
        bus.fifo_usedw     = '0;
        bus.fifo_full      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_rdy(input logic [9:0] u);
        for (int i = 0; i < 12; i++) begin
            if (!bus.fifo_rx_rdy) tick(1'b0, 16'h0, u, 1'b0);
        end
        check("rdy_wait", 32'(bus.fifo_rx_rdy), 32'd1);
    endtask

    initial begin
        int done_cnt;
        int wr_cnt;
        int low_cnt;

        vecs[0] = '{10'd513,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{10'd513,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{10'd1000, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{10'd1000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{10'd512,  1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{10'd512,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{10'd512,  1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b1};
        vecs[7] = '{10'd512,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b1};

        // Reset and release: window opens by the second clock.
        apply_reset();
        tick(1'b0, 16'h0, 10'd0, 1'b0);
        tick(1'b0, 16'h0, 10'd0, 1'b0);
        check("rdy_after_release", 32'(bus.fifo_rx_rdy), 32'd1);

        // Vector table: usedw boundary, full gating, drop in IDLE, first word.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].valid, vecs[i].data, vecs[i].usedw, vecs[i].full);
            check($sformatf("vec%0d_rdy", i),   32'(bus.fifo_rx_rdy), 32'(vecs[i].e_rdy));
            check($sformatf("vec%0d_wrreq", i), 32'(bus.fifo_wrreq),  32'(vecs[i].e_wrreq));
            check($sformatf("vec%0d_data", i),  32'(bus.fifo_data),   32'(vecs[i].e_data));
            check($sformatf("vec%0d_done", i),  32'(bus.burst_done),  32'(vecs[i].e_done));
            check($sformatf("vec%0d_ovf", i),   32'(bus.ovf_err),     32'(vecs[i].e_ovf));
        end

        // Back-to-back burst of 512 words.
        apply_reset();
        wait_rdy(10'd0);
        done_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            tick(1'b1, 16'(i), 10'd0, 1'b0);
            if (bus.burst_done) done_cnt++;
            if (!bus.fifo_wrreq || bus.fifo_data != 16'(i)) check("b2b_word", 32'(bus.fifo_data), 32'(i));
        end
        check("b2b_done_last", 32'(bus.burst_done), 32'd1);
        check("b2b_done_cnt", 32'(done_cnt), 32'd1);
        low_cnt = bus.fifo_rx_rdy ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            if (!bus.fifo_rx_rdy) begin
                tick(1'b0, 16'h0, 10'd0, 1'b0);
                if (!bus.fifo_rx_rdy) low_cnt++;
            end
        end
        check("settle_low_cycles", 32'(low_cnt), 32'(SETTLE_CYC + 1));
        check("b2b_no_ovf", 32'(bus.ovf_err), 32'd0);

        // Sparse burst: a word every third cycle.
        wr_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            tick(1'b1, 16'(16'h4000 + i), 10'd100, 1'b0);
            if (bus.fifo_wrreq) wr_cnt++;
            if (bus.burst_done) done_cnt++;
            for (int k = 0; k < 2; k++) begin
                tick(1'b0, 16'h0, 10'd100, 1'b0);
                if (bus.fifo_wrreq) wr_cnt++;
                if (bus.burst_done) done_cnt++;
            end
            if (i == 510) check("sparse_no_early_done", 32'(done_cnt), 32'd0);
        end
        check("sparse_wr_cnt", 32'(wr_cnt), 32'd512);
        check("sparse_done_cnt", 32'(done_cnt), 32'd1);

        // Reset after word 200 aborts the burst; next burst counts from word 1.
        wait_rdy(10'd0);
        for (int i = 0; i < 200; i++) tick(1'b1, 16'(i), 10'd0, 1'b0);
        check("midburst_wrreq_before", 32'(bus.fifo_wrreq), 32'd1);
        apply_reset();
        wait_rdy(10'd0);
        done_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            tick(1'b1, 16'(16'h8000 + i), 10'd0, 1'b0);
            if (bus.burst_done) done_cnt++;
            if (i == 510) check("restart_no_early_done", 32'(done_cnt), 32'd0);
        end
        check("restart_done_at_512", 32'(bus.burst_done), 32'd1);

        // fifo_full while a write is being issued: write happens, error latches.
        wait_rdy(10'd0);
        tick(1'b1, 16'hBEEF, 10'd0, 1'b0);
        tick(1'b0, 16'h0, 10'd0, 1'b1);
        check("full_on_write_ovf", 32'(bus.ovf_err), 32'd1);
        tick(1'b0, 16'h0, 10'd0, 1'b0);
        check("ovf_sticky", 32'(bus.ovf_err), 32'd1);

        // Randomized traffic against the model, with periodic resets.
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [9:0] u;
            logic       f;
            if (i % 400 == 0) apply_reset();
            v = ($urandom % 4) != 0;
            u = (($urandom % 8) == 0) ? 10'($urandom_range(500, 1023)) : 10'($urandom_range(0, 520));
            f = ($urandom % 32) == 0;
            tick(v, 16'($urandom), u, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
